// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, FSM states and access legality for dmem_responder
package dmem_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Legal funct3 for the direction and natural alignment; range is checked by the caller
  function automatic logic is_legal_access(input logic we, input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
    logic legal;
    case (funct3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = ~addr_lo[0];
      F3_W:    legal = (addr_lo == 2'b00);
      F3_BU:   legal = ~we;
      F3_HU:   legal = ~we & ~addr_lo[0];
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/dmem_responder_lsu_lane_align.sv
// rtl/dmem_responder_lsu_lane_align.sv - little-endian byte-lane steering for stores and load extension
module lsu_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Pick the addressed byte and half out of the read word
  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_rword[7:0];
      2'd1:    w_byte = i_rword[15:8];
      2'd2:    w_byte = i_rword[23:16];
      default: w_byte = i_rword[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
  end

  // Store side: byte enables plus data replicated onto every lane so the enables alone select
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    case (i_funct3)
      F3_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      F3_H: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      F3_W: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
      default: begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
      end
    endcase
  end

  // Load side: sign or zero extension of the selected lanes
  always_comb begin
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'd0, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'd0, w_half};
      F3_W:    o_rdata = i_rword;
      default: o_rdata = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding load/store responder with programmable wait states
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_busy
);

  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAT_M1 = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

  dmem_state_e r_state;
  logic [2:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_live;
  logic          w_acc_we;
  logic [2:0]    w_acc_funct3;
  logic [31:0]   w_acc_addr;
  logic [31:0]   w_acc_wdata;
  logic          w_do_access;
  logic          w_in_range;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rword;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata_rep;
  logic [31:0]   w_load;
  logic [31:0]   w_result;

  // With zero wait states the access uses the request as presented; otherwise the captured copy
  assign w_live       = (r_state == IDLE);
  assign w_acc_we     = w_live ? i_req_we     : r_we;
  assign w_acc_funct3 = w_live ? i_req_funct3 : r_funct3;
  assign w_acc_addr   = w_live ? i_req_addr   : r_addr;
  assign w_acc_wdata  = w_live ? i_req_wdata  : r_wdata;

  assign w_do_access = ((r_state == IDLE) && i_req_valid && (LATENCY == 0)) ||
                       ((r_state == WAIT) && (r_cnt == 3'd0));

  assign w_in_range = ({2'b00, w_acc_addr[31:2]} < 32'(DEPTH_WORDS));
  assign w_err      = ~(is_legal_access(w_acc_we, w_acc_funct3, w_acc_addr[1:0]) & w_in_range);
  assign w_idx      = w_acc_addr[AW+1:2];
  assign w_rword    = r_mem[w_idx];
  assign w_result   = (w_err | w_acc_we) ? 32'd0 : w_load;

  lsu_lane_align u_align (
    .i_funct3  (w_acc_funct3),
    .i_addr_lo (w_acc_addr[1:0]),
    .i_wdata   (w_acc_wdata),
    .i_rword   (w_rword),
    .o_be      (w_be),
    .o_wdata   (w_wdata_rep),
    .o_rdata   (w_load)
  );

  // Array write: byte-lane store on the access edge only, never for faulting requests
  always_ff @(posedge i_clk) begin
    if (w_do_access && w_acc_we && !w_err && !i_reset) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
      end
    end
  end

  // Request FSM: capture, count wait states, hold the response until it is taken
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_we     <= i_req_we;
            r_funct3 <= i_req_funct3;
            r_addr   <= i_req_addr;
            r_wdata  <= i_req_wdata;
            if (LATENCY == 0) begin
              r_rdata <= w_result;
              r_err   <= w_err;
              r_state <= RESP;
            end else begin
              r_cnt   <= LAT_M1;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 3'd0) begin
            r_rdata <= w_result;
            r_err   <= w_err;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP: begin
          if (i_rsp_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready = (r_state == IDLE);
  assign o_rsp_valid = (r_state == RESP);
  assign o_busy      = (r_state != IDLE);
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

endmodule
